// File: rtl/fpu_pkg.sv
// Shared types and constants for the FPU add/sub front end.
package fpu_pkg;

  localparam int unsigned EXP_W  = 32'd8;
  localparam int unsigned FRAC_W = 32'd23;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  // IEEE-754 single precision operand layout.
  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp32_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CLASSIFY = 2'd1,
    ISSUE    = 2'd2,
    WAIT     = 2'd3
  } unpack_state_t;

  // Absolute exponent difference, clamped so that any alignment past the
  // fraction width is reported as a single "shift fully out" value.
  function automatic logic [EXP_W-1:0] align_shift(
    input logic [EXP_W-1:0] a,
    input logic [EXP_W-1:0] b,
    input logic [EXP_W-1:0] sat
  );
    logic [EXP_W:0] diff;
    if (a >= b) begin
      diff = {1'b0, a} - {1'b0, b};
    end else begin
      diff = {1'b0, b} - {1'b0, a};
    end
    if (diff > {1'b0, sat}) begin
      return sat;
    end else begin
      return diff[EXP_W-1:0];
    end
  endfunction

endpackage

// File: rtl/operand_unpacker_if.sv
// Bus between the upstream requester, the operand unpacker and the adder.
interface operand_unpacker_if;

  // Upstream request side
  logic        data_valid_i;
  logic        ready_o;
  logic [31:0] x_i;
  logic [31:0] y_i;
  logic        subtract_i;

  // Adder side
  logic        result_valid_i;
  logic        data_valid_o;
  logic        x_sign_o;
  logic [7:0]  x_exp_o;
  logic [22:0] x_frac_o;
  logic        y_sign_o;
  logic [7:0]  y_exp_o;
  logic [22:0] y_frac_o;
  logic        x_greater_o;
  logic [7:0]  exp_shift_o;
  logic        infinity_o;
  logic        nan_o;
  logic        timeout_o;

  // The unpacker itself
  modport slave (
    input  data_valid_i, x_i, y_i, subtract_i, result_valid_i,
    output ready_o, data_valid_o, x_sign_o, x_exp_o, x_frac_o,
           y_sign_o, y_exp_o, y_frac_o, x_greater_o, exp_shift_o,
           infinity_o, nan_o, timeout_o
  );

  // Whoever drives requests and returns adder completions
  modport master (
    output data_valid_i, x_i, y_i, subtract_i, result_valid_i,
    input  ready_o, data_valid_o, x_sign_o, x_exp_o, x_frac_o,
           y_sign_o, y_exp_o, y_frac_o, x_greater_o, exp_shift_o,
           infinity_o, nan_o, timeout_o
  );

endinterface

// File: rtl/fp_classify.sv
// Combinational special-value classification of one single-precision operand.
module fp_classify
  import fpu_pkg::*;
(
  input  fp32_t op_i,
  output logic  is_zero_o,
  output logic  is_denorm_o,
  output logic  is_inf_o,
  output logic  is_nan_o
);

  logic exp_min_s;
  logic exp_max_s;
  logic frac_zero_s;

  assign exp_min_s   = (op_i.exp == {EXP_W{1'b0}});
  assign exp_max_s   = (op_i.exp == EXP_MAX);
  assign frac_zero_s = (op_i.frac == {FRAC_W{1'b0}});

  assign is_zero_o   = exp_min_s & frac_zero_s;
  assign is_denorm_o = exp_min_s & ~frac_zero_s;
  assign is_inf_o    = exp_max_s & frac_zero_s;
  assign is_nan_o    = exp_max_s & ~frac_zero_s;

endmodule

// File: rtl/operand_unpacker.sv
// Front stage of the FPU add/sub path: captures an operand pair, decomposes
// and classifies it, issues one pulse to the adder and waits for completion.
module operand_unpacker
  import fpu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 32'd16,
  parameter int unsigned SHIFT_SAT      = 32'd24
) (
  input logic               clk_i,
  input logic               rst_i,
  operand_unpacker_if.slave bus
);

  localparam int unsigned      CNT_W       = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(TIMEOUT_CYCLES - 32'd1);
  localparam logic [EXP_W-1:0] SHIFT_SAT_V = EXP_W'(SHIFT_SAT);

  unpack_state_t     state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  fp32_t             x_q, x_d;
  fp32_t             y_q, y_d;
  logic              sub_q, sub_d;

  logic              data_valid_q, data_valid_d;
  logic              timeout_q, timeout_d;
  logic              x_sign_q, x_sign_d;
  logic [EXP_W-1:0]  x_exp_q, x_exp_d;
  logic [FRAC_W-1:0] x_frac_q, x_frac_d;
  logic              y_sign_q, y_sign_d;
  logic [EXP_W-1:0]  y_exp_q, y_exp_d;
  logic [FRAC_W-1:0] y_frac_q, y_frac_d;
  logic              x_greater_q, x_greater_d;
  logic [EXP_W-1:0]  exp_shift_q, exp_shift_d;
  logic              infinity_q, infinity_d;
  logic              nan_q, nan_d;

  logic x_zero_s, x_denorm_s, x_inf_s, x_nan_s;
  logic y_zero_s, y_denorm_s, y_inf_s, y_nan_s;

  logic [FRAC_W-1:0] x_frac_flush_s;
  logic [FRAC_W-1:0] y_frac_flush_s;
  logic              y_sign_eff_s;
  logic              x_greater_s;
  logic [EXP_W-1:0]  exp_shift_s;
  logic              nan_s;
  logic              infinity_s;

  fp_classify u_x_classify (
    .op_i        (x_q),
    .is_zero_o   (x_zero_s),
    .is_denorm_o (x_denorm_s),
    .is_inf_o    (x_inf_s),
    .is_nan_o    (x_nan_s)
  );

  fp_classify u_y_classify (
    .op_i        (y_q),
    .is_zero_o   (y_zero_s),
    .is_denorm_o (y_denorm_s),
    .is_inf_o    (y_inf_s),
    .is_nan_o    (y_nan_s)
  );

  // Denormals are flushed: a zero exponent means the operand is treated as zero.
  assign x_frac_flush_s = (x_zero_s | x_denorm_s) ? {FRAC_W{1'b0}} : x_q.frac;
  assign y_frac_flush_s = (y_zero_s | y_denorm_s) ? {FRAC_W{1'b0}} : y_q.frac;

  // Subtraction is folded into y's sign so the adder only ever adds.
  assign y_sign_eff_s = y_q.sign ^ sub_q;
  assign x_greater_s  = ({x_q.exp, x_frac_flush_s} >= {y_q.exp, y_frac_flush_s});
  assign exp_shift_s  = align_shift(x_q.exp, y_q.exp, SHIFT_SAT_V);

  // inf - inf (after folding the subtract) has no defined value.
  assign nan_s      = x_nan_s | y_nan_s | (x_inf_s & y_inf_s & (x_q.sign ^ y_sign_eff_s));
  assign infinity_s = (x_inf_s | y_inf_s) & ~nan_s;

  // Next-state, capture and output-register logic of the handshake FSM.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    x_d          = x_q;
    y_d          = y_q;
    sub_d        = sub_q;
    data_valid_d = 1'b0;
    timeout_d    = 1'b0;
    x_sign_d     = x_sign_q;
    x_exp_d      = x_exp_q;
    x_frac_d     = x_frac_q;
    y_sign_d     = y_sign_q;
    y_exp_d      = y_exp_q;
    y_frac_d     = y_frac_q;
    x_greater_d  = x_greater_q;
    exp_shift_d  = exp_shift_q;
    infinity_d   = infinity_q;
    nan_d        = nan_q;

    case (state_q)
      IDLE: begin
        if (bus.data_valid_i) begin
          x_d     = fp32_t'(bus.x_i);
          y_d     = fp32_t'(bus.y_i);
          sub_d   = bus.subtract_i;
          state_d = CLASSIFY;
        end else begin
          state_d = IDLE;
        end
      end
      CLASSIFY: begin
        x_sign_d     = x_q.sign;
        x_exp_d      = x_q.exp;
        x_frac_d     = x_frac_flush_s;
        y_sign_d     = y_sign_eff_s;
        y_exp_d      = y_q.exp;
        y_frac_d     = y_frac_flush_s;
        x_greater_d  = x_greater_s;
        exp_shift_d  = exp_shift_s;
        infinity_d   = infinity_s;
        nan_d        = nan_s;
        // Registered so the pulse is high exactly while in ISSUE.
        data_valid_d = 1'b1;
        state_d      = ISSUE;
      end
      ISSUE: begin
        cnt_d   = {CNT_W{1'b0}};
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.result_valid_i) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      cnt_q        <= {CNT_W{1'b0}};
      x_q          <= '0;
      y_q          <= '0;
      sub_q        <= 1'b0;
      data_valid_q <= 1'b0;
      timeout_q    <= 1'b0;
      x_sign_q     <= 1'b0;
      x_exp_q      <= {EXP_W{1'b0}};
      x_frac_q     <= {FRAC_W{1'b0}};
      y_sign_q     <= 1'b0;
      y_exp_q      <= {EXP_W{1'b0}};
      y_frac_q     <= {FRAC_W{1'b0}};
      x_greater_q  <= 1'b0;
      exp_shift_q  <= {EXP_W{1'b0}};
      infinity_q   <= 1'b0;
      nan_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      x_q          <= x_d;
      y_q          <= y_d;
      sub_q        <= sub_d;
      data_valid_q <= data_valid_d;
      timeout_q    <= timeout_d;
      x_sign_q     <= x_sign_d;
      x_exp_q      <= x_exp_d;
      x_frac_q     <= x_frac_d;
      y_sign_q     <= y_sign_d;
      y_exp_q      <= y_exp_d;
      y_frac_q     <= y_frac_d;
      x_greater_q  <= x_greater_d;
      exp_shift_q  <= exp_shift_d;
      infinity_q   <= infinity_d;
      nan_q        <= nan_d;
    end
  end

  assign bus.ready_o      = (state_q == IDLE);
  assign bus.data_valid_o = data_valid_q;
  assign bus.timeout_o    = timeout_q;
  assign bus.x_sign_o     = x_sign_q;
  assign bus.x_exp_o      = x_exp_q;
  assign bus.x_frac_o     = x_frac_q;
  assign bus.y_sign_o     = y_sign_q;
  assign bus.y_exp_o      = y_exp_q;
  assign bus.y_frac_o     = y_frac_q;
  assign bus.x_greater_o  = x_greater_q;
  assign bus.exp_shift_o  = exp_shift_q;
  assign bus.infinity_o   = infinity_q;
  assign bus.nan_o        = nan_q;

endmodule

// File: tb/tb_operand_unpacker.sv
// Scoreboard bench for operand_unpacker: directed spec cases plus random ops.
module tb_operand_unpacker;

  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  operand_unpacker_if bus();

  operand_unpacker #(
    .TIMEOUT_CYCLES (TIMEOUT),
    .SHIFT_SAT      (24)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int checks = 0;
  int passes = 0;
  logic [74:0] exp_q[$];

  // Reference: IEEE-754 field rules written directly from the operand bits.
  function automatic logic [74:0] model(input logic [31:0] x, input logic [31:0] y, input logic sub);
    int ex, ey, d;
    longint mx, my;
    logic ys, xnan, ynan, xinf, yinf, nan, inf;
    logic [22:0] xf, yf;
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    xf = (ex == 0) ? 23'd0 : x[22:0];
    yf = (ey == 0) ? 23'd0 : y[22:0];
    // Magnitude ordering of IEEE values equals ordering of their low 31 bits.
    mx = (ex == 0) ? longint'(0) : longint'(x[30:0]);
    my = (ey == 0) ? longint'(0) : longint'(y[30:0]);
    d = (ex > ey) ? ex - ey : ey - ex;
    if (d > 24) d = 24;
    ys   = y[31] ^ sub;
    xnan = (ex == 255) && (x[22:0] != 23'd0);
    ynan = (ey == 255) && (y[22:0] != 23'd0);
    xinf = (ex == 255) && (x[22:0] == 23'd0);
    yinf = (ey == 255) && (y[22:0] == 23'd0);
    nan  = xnan || ynan || (xinf && yinf && (x[31] != ys));
    inf  = (xinf || yinf) && !nan;
    return {x[31], x[30:23], xf, ys, y[30:23], yf, (mx >= my), d[7:0], inf, nan};
  endfunction

  function automatic logic [74:0] dut_vec();
    return {bus.x_sign_o, bus.x_exp_o, bus.x_frac_o, bus.y_sign_o, bus.y_exp_o,
            bus.y_frac_o, bus.x_greater_o, bus.exp_shift_o, bus.infinity_o, bus.nan_o};
  endfunction

  task automatic check(input string name, input logic [74:0] act, input logic [74:0] req);
    checks++;
    if (act === req) begin
      passes++;
    end else begin
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: every adder issue is compared with the oldest expected result.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.data_valid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_issue: data_valid_o=1 with no op pending, expected 0");
      end else begin
        check("issued_operands", dut_vec(), exp_q.pop_front());
      end
    end
  end

  // resp >= 0: result after resp WAIT cycles; -1: let it time out; -2: stop in WAIT.
  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic sub,
                        input int resp, input logic hold,
                        input logic [31:0] hx, input logic [31:0] hy, input logic hs);
    int n;
    check("ready_before_issue", 75'(bus.ready_o), 75'd1);
    exp_q.push_back(model(x, y, sub));
    bus.data_valid_i = 1'b1;
    bus.x_i = x;
    bus.y_i = y;
    bus.subtract_i = sub;
    @(posedge clk); #1;  // acceptance edge N
    bus.data_valid_i = 1'b0;
    check("ready_busy", 75'(bus.ready_o), 75'd0);
    // data_valid_o belongs to cycle N+2, i.e. it is seen after edge N+1.
    n = 0;
    while (bus.data_valid_o !== 1'b1 && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    check("issue_latency", 75'(n), 75'd1);
    @(posedge clk); #1;  // now in WAIT
    check("issue_single_pulse", 75'(bus.data_valid_o), 75'd0);
    if (hold) begin
      bus.data_valid_i = 1'b1;
      bus.x_i = hx;
      bus.y_i = hy;
      bus.subtract_i = hs;
    end
    if (resp >= 0) begin
      repeat (resp) begin
        @(posedge clk); #1;
      end
      if (hold) check("ready_low_in_wait", 75'(bus.ready_o), 75'd0);
      bus.result_valid_i = 1'b1;
      @(posedge clk); #1;
      bus.result_valid_i = 1'b0;
      check("ready_after_result", 75'(bus.ready_o), 75'd1);
      check("no_timeout_on_result", 75'(bus.timeout_o), 75'd0);
    end else if (resp == -1) begin
      n = 0;
      while (bus.timeout_o !== 1'b1 && n < 40) begin
        @(posedge clk); #1;
        n++;
      end
      check("timeout_delay", 75'(n), 75'(TIMEOUT));
      check("ready_after_timeout", 75'(bus.ready_o), 75'd1);
      @(posedge clk); #1;
      check("timeout_single_pulse", 75'(bus.timeout_o), 75'd0);
    end
  endtask

  function automatic logic [31:0] rand_fp();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 5))
      0: r[30:23] = 8'h00;
      1: begin r[30:23] = 8'hFF; r[22:0] = 23'd0; end
      2: r[30:23] = 8'hFF;
      3: r[30:23] = 8'($urandom_range(120, 135));
      default: ;
    endcase
    return r;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] hx, hy;
    rst = 1'b1;
    bus.data_valid_i = 1'b0;
    bus.x_i = 32'd0;
    bus.y_i = 32'd0;
    bus.subtract_i = 1'b0;
    bus.result_valid_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("reset_outputs", dut_vec(), 75'd0);
    check("reset_valid", 75'(bus.data_valid_o), 75'd0);
    check("reset_timeout", 75'(bus.timeout_o), 75'd0);
    check("reset_ready", 75'(bus.ready_o), 75'd1);

    // Directed cases
    run_op(32'h3F800000, 32'h40000000, 1'b0, 2, 1'b0, 32'd0, 32'd0, 1'b0);
    run_op(32'h40400000, 32'h3F800000, 1'b1, 0, 1'b0, 32'd0, 32'd0, 1'b0);
    run_op(32'h7F800000, 32'hFF800000, 1'b0, 1, 1'b0, 32'd0, 32'd0, 1'b0);
    run_op(32'h7F800000, 32'h3F800000, 1'b0, 1, 1'b0, 32'd0, 32'd0, 1'b0);
    run_op(32'h7F000000, 32'h00800000, 1'b0, 1, 1'b0, 32'd0, 32'd0, 1'b0);
    run_op(32'h3F800000, 32'h00000001, 1'b0, 1, 1'b0, 32'd0, 32'd0, 1'b0);

    // Request held through WAIT must not be captured until ready returns.
    hx = 32'hC1200000;
    hy = 32'h3E800000;
    run_op(32'h40A00000, 32'h40A00000, 1'b1, 3, 1'b1, hx, hy, 1'b1);
    run_op(hx, hy, 1'b1, 0, 1'b0, 32'd0, 32'd0, 1'b0);

    // No completion from the adder.
    run_op(32'h41000000, 32'hBF800000, 1'b0, -1, 1'b0, 32'd0, 32'd0, 1'b0);

    // Reset while waiting drops the op; the next one completes normally.
    run_op(32'h42000000, 32'h41000000, 1'b0, -2, 1'b0, 32'd0, 32'd0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("wait_reset_outputs", dut_vec(), 75'd0);
    check("wait_reset_valid", 75'(bus.data_valid_o), 75'd0);
    check("wait_reset_ready", 75'(bus.ready_o), 75'd1);
    rst = 1'b0;
    run_op(32'h3FC00000, 32'hBFC00000, 1'b1, 2, 1'b0, 32'd0, 32'd0, 1'b0);

    // Random traffic
    for (int i = 0; i < 40; i++) begin
      run_op(rand_fp(), rand_fp(), 1'($urandom_range(0, 1)), int'($urandom_range(0, 4)),
             1'b0, 32'd0, 32'd0, 1'b0);
    end

    repeat (2) @(posedge clk);
    #1;
    check("scoreboard_drained", 75'(exp_q.size()), 75'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
